// File: rtl/control_div_pkg.sv
// Shared definitions for the restoring-divider controller: operand width,
// FSM state encodings and the Moore strobe decode.
package control_div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_LOAD  = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Registered controller outputs, one bit per strobe/status line
  typedef struct packed {
    logic init;
    logic sh;
    logic lda;
    logic dv0;
    logic busy;
    logic done;
  } strobe_t;

  // Output decode for a given state; at most one datapath strobe is set
  function automatic strobe_t decode(state_t s);
    strobe_t o;
    o      = '0;
    o.busy = (s != S_IDLE);
    case (s)
      S_START: o.init = 1'b1;
      S_SHIFT: o.sh   = 1'b1;
      S_LOAD:  o.lda  = 1'b1;
      S_OUT:   o.dv0  = 1'b1;
      S_DONE:  o.done = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sub_cmp_div.sv
// Compare/subtract stage: unsigned A >= DR and the trial remainder A - DR.
module sub_cmp_div #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] dr,
  output logic             ge,
  output logic [WIDTH-1:0] diff
);

  // Difference wraps modulo 2^WIDTH; it is only consumed when ge is set
  always_comb begin
    ge   = (a >= dr);
    diff = a - dr;
  end

endmodule

// File: rtl/control_div.sv
// Sequencer for the 16-bit shift-subtract divider. Issues INIT, then WIDTH
// shift/compare iterations (with a load whenever A >= DR), then copies the
// quotient out and pulses done. DR == 0 short-circuits straight to DONE.
module control_div
  import control_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] DR,
  input  logic [WIDTH-1:0] A,
  output logic             INIT,
  output logic             SH,
  output logic             LDA,
  output logic             DV0,
  output logic [WIDTH-1:0] IN_A,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  state_t           state, nxt;
  strobe_t          strb;
  logic [CNT_W-1:0] cnt;
  logic             a_ge_dr;

  sub_cmp_div #(.WIDTH(WIDTH)) u_cmp (
    .a    (A),
    .dr   (DR),
    .ge   (a_ge_dr),
    .diff (IN_A)
  );

  // Next-state selection. CHECK sees the pre-increment count, LOAD the
  // post-increment one, so both exits fire after exactly WIDTH iterations.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (init) nxt = S_START;
      S_START: nxt = (DR == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: nxt = S_CHECK;
      S_CHECK: begin
        if (a_ge_dr)              nxt = S_LOAD;
        else if (cnt == CNT_LAST) nxt = S_OUT;
        else                      nxt = S_SHIFT;
      end
      S_LOAD:  nxt = (cnt == CNT_FULL) ? S_OUT : S_SHIFT;
      S_OUT:   nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // State, iteration counter, sticky divide-by-zero flag and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_zero <= 1'b0;
      strb     <= '0;
    end else begin
      state <= nxt;
      strb  <= decode(nxt);
      case (state)
        S_START: begin
          cnt      <= '0;
          div_zero <= (DR == '0);
        end
        S_CHECK: cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign INIT = strb.init;
  assign SH   = strb.sh;
  assign LDA  = strb.lda;
  assign DV0  = strb.dv0;
  assign busy = strb.busy;
  assign done = strb.done;

endmodule

// File: tb/tb_control_div.sv
// Bench for control_div with a behavioural divider datapath. The driver
// pushes the arithmetic result (quotient, remainder, latency, pulse counts)
// into a scoreboard; a monitor pops and compares whenever done is seen.
module tb_control_div;
  import control_div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic         clk = 1'b0;
  logic         rst, init;
  logic [W-1:0] DR, IN_A;
  logic         INIT, SH, LDA, DV0, busy, done, div_zero;

  // datapath registers
  logic [W-1:0] A = '0, q_reg = '0, out_r = '0, dv_in = '0;

  always #5 clk = ~clk;

  control_div dut (
    .clk(clk), .rst(rst), .init(init), .DR(DR), .A(A),
    .INIT(INIT), .SH(SH), .LDA(LDA), .DV0(DV0), .IN_A(IN_A),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  // Datapath: acts on the controller strobes at the falling edge
  always @(negedge clk) begin
    if (INIT) begin
      A <= '0; q_reg <= dv_in; out_r <= '0;
    end else if (SH) begin
      {A, q_reg} <= {A, q_reg} << 1;
    end else if (LDA) begin
      A <= IN_A; q_reg[0] <= 1'b1;
    end else if (DV0) begin
      out_r <= q_reg;
    end
  end

  typedef struct {
    logic [W-1:0] q, r;
    bit           dz;
    int           lat, lda, sh, dv0;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0, fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference result from plain integer division
  function automatic exp_t model(input int dv, input int dr);
    exp_t e;
    if (dr == 0) begin
      e.q = '0; e.r = '0; e.dz = 1'b1; e.lat = 2; e.lda = 0; e.sh = 0; e.dv0 = 0;
    end else begin
      e.q   = W'(dv / dr);
      e.r   = W'(dv % dr);
      e.dz  = 1'b0;
      e.lda = $countones(e.q);
      e.lat = 1 + 2 * W + e.lda + 2;
      e.sh  = W;
      e.dv0 = 1;
    end
    return e;
  endfunction

  // Monitor: tracks an operation from its INIT strobe, compares on done
  int cyc = 0, edge0 = 0, n_sh = 0, n_lda = 0, n_dv0 = 0;
  bit in_op = 0, multi = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (!rst) begin
      in_op = 0;
    end else begin
      if (INIT) begin
        in_op = 1; edge0 = cyc - 1; n_sh = 0; n_lda = 0; n_dv0 = 0; multi = 0;
      end
      if (in_op) begin
        n_sh  += int'(SH);
        n_lda += int'(LDA);
        n_dv0 += int'(DV0);
        if (int'(INIT) + int'(SH) + int'(LDA) + int'(DV0) > 1) multi = 1;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sbq.pop_front();
          chk("quotient", longint'(out_r), longint'(e.q));
          if (!e.dz) chk("remainder", longint'(A), longint'(e.r));
          chk("div_zero", longint'(div_zero), longint'(e.dz));
          chk("latency", cyc - edge0, e.lat);
          chk("lda_pulses", n_lda, e.lda);
          chk("sh_pulses", n_sh, e.sh);
          chk("dv0_pulses", n_dv0, e.dv0);
          chk("strobe_overlap", longint'(multi), 0);
        end
        in_op = 0;
      end
    end
  end

  // One operation; optional init pokes while busy and optional mid-run reset
  task automatic run_div(input int dv, input int dr, input bit push,
                         input int poke1, input int poke2, input int abort_at);
    int c;
    bit seen;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    @(negedge clk);
    dv_in = W'(dv); DR = W'(dr); init = 1'b1;
    if (push) sbq.push_back(model(dv, dr));
    @(negedge clk);
    init = 1'b0; c = 1; seen = 0;
    while (c < 200 && !seen) begin
      if (abort_at == c) begin
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", longint'({INIT, SH, LDA, DV0, busy, done, div_zero}), 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (done) seen = 1;
      init = (c == poke1 || c == poke2);
      @(negedge clk);
      c++;
    end
    init = 1'b0;
    if (!seen) begin
      tests++; fails++;
      $display("FAIL timeout: got no done expected done for %0d/%0d", dv, dr);
    end
  endtask

  // init held high across DONE: two back-to-back operations on the same operands
  task automatic run_held(input int dv, input int dr);
    int nd;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    @(negedge clk);
    dv_in = W'(dv); DR = W'(dr); init = 1'b1;
    sbq.push_back(model(dv, dr));
    sbq.push_back(model(dv, dr));
    nd = 0;
    for (int c = 0; c < 300 && nd < 2; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (nd == 1 && INIT) init = 1'b0;
    end
    init = 1'b0;
    if (nd < 2) begin
      tests++; fails++;
      $display("FAIL held_init_timeout: got %0d dones expected 2", nd);
    end
  endtask

  initial begin
    int dv, dr;
    rst = 1'b0; init = 1'b0; DR = '0;
    #12;
    chk("reset_outputs", longint'({INIT, SH, LDA, DV0, busy, done, div_zero}), 0);
    @(negedge clk);
    rst = 1'b1;

    run_div(100, 7, 1, 0, 0, 0);
    run_div(65535, 1, 1, 0, 0, 0);
    run_div(5, 9, 1, 0, 0, 0);
    run_div(1234, 0, 1, 0, 0, 0);
    run_div(100, 7, 0, 0, 0, 10);
    run_div(40, 6, 1, 0, 0, 0);
    run_div(100, 7, 1, 5, 20, 0);
    run_div(0, 3, 1, 0, 0, 0);
    run_div(32767, 32768, 1, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      dv = int'($urandom_range(0, 65535));
      case ($urandom_range(0, 4))
        0:       dr = 0;
        1:       dr = int'($urandom_range(1, 15));
        default: dr = int'($urandom_range(1, 32768));
      endcase
      run_div(dv, dr, 1, 0, 0, 0);
    end

    run_held(1000, 13);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
